tb_pulse_gen: RTL and testbench



---
 rtl/tb_pkg.sv | 18 +
 rtl/tb_axis.sv | 91 +++++++++
 rtl/tb_pulse_gen.sv | 86 ++++++++
 tb/tb_tb_pulse_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pkg.sv
// Shared constants and types for the PS/2 mouse to quadrature pulse generator.
package tb_pkg;

  // One quadrature count corresponds to four accumulator units
  localparam int STEP_UNIT = 4;

  // Default signed accumulator width per axis
  localparam int ACC_W_DEFAULT = 14;

  // Mouse speed selection: the delta is shifted left by this code
  typedef enum logic [1:0] {
    SPD_25  = 2'd0,
    SPD_50  = 2'd1,
    SPD_100 = 2'd2,
    SPD_200 = 2'd3
  } speed_e;

endpackage

// File: rtl/tb_axis.sv
// One axis of the pulse generator: accumulates scaled mouse deltas in quarter-step
// units and converts them into a count toggle plus a direction line, at most one
// count per tick. A direction change always costs one tick of setup before counting.
module tb_axis
  import tb_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter bit INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_accept,
  input  logic [8:0] i_delta,
  input  logic       i_ovf,
  input  speed_e     i_speed,
  input  logic       i_flip,
  output logic       o_clk,
  output logic       o_dir
);

  // Two guard bits so the raw sum can never wrap before saturation
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] STEP_POS = SUM_W'(STEP_UNIT);
  localparam logic signed [SUM_W-1:0] STEP_NEG = -STEP_POS;
  localparam logic signed [SUM_W-1:0] ACC_MAX  = (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] ACC_MIN  = ~ACC_MAX;

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_clk;
  logic                    r_dir;

  logic signed [SUM_W-1:0] w_accExt;
  logic signed [SUM_W-1:0] w_scaled;
  logic signed [SUM_W-1:0] w_addend;
  logic signed [SUM_W-1:0] w_consume;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_accNext;
  logic                    w_nonNeg;
  logic                    w_big;
  logic                    w_reqDir;
  logic                    w_step;
  logic                    w_setup;

  // Decide this cycle's step action and the saturated next accumulator value
  always_comb begin
    w_accExt  = SUM_W'(r_acc);
    w_scaled  = SUM_W'($signed(i_delta)) <<< i_speed;
    w_addend  = '0;
    if (i_accept && !i_ovf) begin
      w_addend = w_scaled;
    end
    w_nonNeg  = ~r_acc[ACC_W-1];
    w_big     = (w_accExt >= STEP_POS) || (w_accExt <= STEP_NEG);
    w_reqDir  = w_nonNeg ^ INVERT ^ i_flip;
    w_step    = i_tick && w_big && (w_reqDir == r_dir);
    w_setup   = i_tick && w_big && (w_reqDir != r_dir);
    w_consume = '0;
    if (w_step) begin
      w_consume = w_nonNeg ? STEP_POS : STEP_NEG;
    end
    w_sum     = w_accExt + w_addend - w_consume;
    w_accNext = w_sum[ACC_W-1:0];
    if (w_sum > ACC_MAX) begin
      w_accNext = ACC_MAX[ACC_W-1:0];
    end else if (w_sum < ACC_MIN) begin
      w_accNext = ACC_MIN[ACC_W-1:0];
    end
  end

  // Register accumulator, count toggle and direction; reset drops any residue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_clk <= 1'b0;
      r_dir <= 1'b0;
    end else begin
      r_acc <= w_accNext;
      if (w_step) begin
        r_clk <= ~r_clk;
      end
      if (w_setup) begin
        r_dir <= w_reqDir;
      end
    end
  end

  assign o_clk = r_clk;
  assign o_dir = r_dir;

endmodule

// File: rtl/tb_pulse_gen.sv
// PS/2 mouse packet to dual-axis quadrature count/direction generator. Packets are
// detected by a toggling strobe bit; both axes step on a shared periodic tick.
module tb_pulse_gen
  import tb_pkg::*;
#(
  parameter int STEP_DIV = 250,
  parameter int ACC_W    = ACC_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [1:0]  mouse_speed,
  input  logic        flip,
  output logic        h_clk,
  output logic        h_dir,
  output logic        v_clk,
  output logic        v_dir
);

  localparam int              CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] r_tickCnt;
  logic             r_strobe;
  logic             w_tick;
  logic             w_accept;
  speed_e           w_speed;
  logic [8:0]       w_deltaX;
  logic [8:0]       w_deltaY;
  logic             w_unusedFlags;

  // Tick fires in the cycle where the counter wraps back to zero
  assign w_tick        = (r_tickCnt == CNT_LAST);
  assign w_accept      = ps2_mouse[24] ^ r_strobe;
  assign w_speed       = speed_e'(mouse_speed);
  assign w_deltaX      = {ps2_mouse[4], ps2_mouse[15:8]};
  assign w_deltaY      = {ps2_mouse[5], ps2_mouse[23:16]};
  assign w_unusedFlags = ^ps2_mouse[3:0];

  // Free-running step tick divider
  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + CNT_W'(1);
    end
  end

  // Previous strobe value; loading it during reset too keeps the first cycle out of packet detection
  always_ff @(posedge clk) begin
    r_strobe <= ps2_mouse[24];
  end

  tb_axis #(
    .ACC_W  (ACC_W),
    .INVERT (1'b0)
  ) u_axisX (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (w_tick),
    .i_accept (w_accept),
    .i_delta  (w_deltaX),
    .i_ovf    (ps2_mouse[6]),
    .i_speed  (w_speed),
    .i_flip   (flip),
    .o_clk    (h_clk),
    .o_dir    (h_dir)
  );

  tb_axis #(
    .ACC_W  (ACC_W),
    .INVERT (1'b1)
  ) u_axisY (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (w_tick),
    .i_accept (w_accept),
    .i_delta  (w_deltaY),
    .i_ovf    (ps2_mouse[7]),
    .i_speed  (w_speed),
    .i_flip   (flip),
    .o_clk    (v_clk),
    .o_dir    (v_dir)
  );

endmodule

// File: tb/tb_tb_pulse_gen.sv
// Scoreboard bench for tb_pulse_gen: expected output events are queued per axis
// when packets are sent; a monitor pops and compares each observed output change.
module tb_tb_pulse_gen;
  import tb_pkg::*;

  localparam int STEP_DIV = 4;
  localparam int ACC_W    = 14;

  // Event codes: 0 = count toggle, 1 = direction to 0, 2 = direction to 1
  localparam int EV_TOG  = 0;
  localparam int EV_DIR0 = 1;
  localparam int EV_DIR1 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] ps2Mouse = '0;
  logic [1:0]  mouseSpeed = 2'd0;
  logic        flip = 1'b0;
  logic        hClk, hDir, vClk, vDir;

  int compared = 0;
  int mismatched = 0;
  int qH[$];
  int qV[$];
  bit freeRunH = 1'b0;
  int hDirChanges = 0;
  int mCnt = 0;
  logic pH, pHd, pV, pVd;

  always #5 clk = ~clk;

  tb_pulse_gen #(
    .STEP_DIV (STEP_DIV),
    .ACC_W    (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_mouse   (ps2Mouse),
    .mouse_speed (mouseSpeed),
    .flip        (flip),
    .h_clk       (hClk),
    .h_dir       (hDir),
    .v_clk       (vClk),
    .v_dir       (vDir)
  );

  // Reference tick timing: a tick occupies the cycle in which the count is STEP_DIV-1
  always @(posedge clk) begin
    if (reset || mCnt == STEP_DIV - 1) mCnt <= 0;
    else mCnt <= mCnt + 1;
  end

  function automatic string evName(input int ev);
    case (ev)
      EV_TOG:  return "toggle";
      EV_DIR0: return "dir->0";
      EV_DIR1: return "dir->1";
      default: return "none";
    endcase
  endfunction

  task automatic checkVal(input string name, input int act, input int want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  task automatic handleEvent(input bit isV, input int act, input bit wasTick);
    int want;
    string nm;
    nm = isV ? "v" : "h";
    compared++;
    if (!wasTick) begin
      mismatched++;
      $display("[TB] FAIL %s_timing: %s at %0t not one cycle after a tick, required tick-aligned",
               nm, evName(act), $time);
    end
    if (!isV && freeRunH) begin
      if (act != EV_TOG) hDirChanges++;
      return;
    end
    want = -1;
    if (isV) begin
      if (qV.size() > 0) want = qV.pop_front();
    end else begin
      if (qH.size() > 0) want = qH.pop_front();
    end
    compared++;
    if (act != want) begin
      mismatched++;
      $display("[TB] FAIL %s_event: got %s at %0t, required %s", nm, evName(act), $time, evName(want));
    end
  endtask

  // Monitor: every output change after a non-reset edge is a scoreboard event
  initial begin : monitor
    bit wasTick;
    bit wasReset;
    forever begin
      @(posedge clk);
      wasTick  = (mCnt == STEP_DIV - 1);
      wasReset = reset;
      #1;
      if (!wasReset) begin
        if (hDir !== pHd) handleEvent(1'b0, hDir ? EV_DIR1 : EV_DIR0, wasTick);
        if (hClk !== pH)  handleEvent(1'b0, EV_TOG, wasTick);
        if (vDir !== pVd) handleEvent(1'b1, vDir ? EV_DIR1 : EV_DIR0, wasTick);
        if (vClk !== pV)  handleEvent(1'b1, EV_TOG, wasTick);
      end
      pH = hClk; pHd = hDir; pV = vClk; pVd = vDir;
    end
  end

  // Send one packet: the strobe toggle makes this cycle the accept cycle
  task automatic applyStimulus(input logic signed [8:0] dx, input logic signed [8:0] dy,
                               input logic xOvf, input logic yOvf, input logic [1:0] spd);
    @(posedge clk); #2;
    mouseSpeed      = spd;
    ps2Mouse[23:16] = dy[7:0];
    ps2Mouse[15:8]  = dx[7:0];
    ps2Mouse[7:0]   = {yOvf, xOvf, dy[8], dx[8], 4'b0000};
    ps2Mouse[24]    = ~ps2Mouse[24];
  endtask

  task automatic waitQueues(input int maxH, input int maxV, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((qH.size() > maxH || qV.size() > maxV) && n < budget);
    compared++;
    if (qH.size() > maxH || qV.size() > maxV) begin
      mismatched++;
      $display("[TB] FAIL %s: queues hold h=%0d v=%0d after %0d cycles, required h<=%0d v<=%0d",
               name, qH.size(), qV.size(), n, maxH, maxV);
    end
  endtask

  task automatic checkOutput(input string name, input int idle);
    repeat (idle) @(posedge clk);
    #2;
    checkVal({name, "_hPending"}, qH.size(), 0);
    checkVal({name, "_vPending"}, qV.size(), 0);
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset = 1'b1;
    flip  = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    checkVal("reset_hClk", int'(hClk), 0);
    checkVal("reset_hDir", int'(hDir), 0);
    checkVal("reset_vClk", int'(vClk), 0);
    checkVal("reset_vDir", int'(vDir), 0);
    checkVal("reset_accX", int'(dut.u_axisX.r_acc), 0);

    $display("[TB] dx=+3 dy=+2 at 100%%: X setup then 3 counts, Y 2 counts without setup");
    qH.push_back(EV_DIR1); qH.push_back(EV_TOG); qH.push_back(EV_TOG); qH.push_back(EV_TOG);
    qV.push_back(EV_TOG); qV.push_back(EV_TOG);
    applyStimulus(9'sd3, 9'sd2, 1'b0, 1'b0, 2'd2);
    waitQueues(0, 0, 60, "s1_drain");
    checkOutput("s1", 12);
    checkVal("s1_hDir", int'(hDir), 1);
    checkVal("s1_accX", int'(dut.u_axisX.r_acc), 0);
    checkVal("s1_accY", int'(dut.u_axisY.r_acc), 0);

    $display("[TB] dx=+1 four times at 25%%: residue retained until the fourth packet");
    doReset();
    repeat (3) applyStimulus(9'sd1, 9'sd0, 1'b0, 1'b0, 2'd0);
    checkOutput("s2_residue", 20);
    checkVal("s2_accX", int'(dut.u_axisX.r_acc), 3);
    qH.push_back(EV_DIR1); qH.push_back(EV_TOG);
    applyStimulus(9'sd1, 9'sd0, 1'b0, 1'b0, 2'd0);
    waitQueues(0, 0, 40, "s2_drain");
    checkOutput("s2", 12);
    checkVal("s2_accXEnd", int'(dut.u_axisX.r_acc), 0);

    $display("[TB] dx=+8 then dx=-8 mid-stream at 100%%: reversal through a setup tick");
    doReset();
    qH.push_back(EV_DIR1); qH.push_back(EV_TOG); qH.push_back(EV_TOG);
    applyStimulus(9'sd8, 9'sd0, 1'b0, 1'b0, 2'd2);
    waitQueues(0, 0, 40, "s3_first");
    qH.push_back(EV_DIR0); qH.push_back(EV_TOG); qH.push_back(EV_TOG);
    applyStimulus(-9'sd8, 9'sd0, 1'b0, 1'b0, 2'd2);
    waitQueues(0, 0, 40, "s3_drain");
    checkOutput("s3", 12);
    checkVal("s3_hDir", int'(hDir), 0);
    checkVal("s3_accX", int'(dut.u_axisX.r_acc), 0);

    $display("[TB] X overflow with dx=+100, dy=-2 at 100%%: only Y moves");
    doReset();
    qV.push_back(EV_DIR1); qV.push_back(EV_TOG); qV.push_back(EV_TOG);
    applyStimulus(9'sd100, -9'sd2, 1'b1, 1'b0, 2'd2);
    waitQueues(0, 0, 40, "s4_drain");
    checkOutput("s4", 12);
    checkVal("s4_vDir", int'(vDir), 1);
    checkVal("s4_accX", int'(dut.u_axisX.r_acc), 0);
    checkVal("s4_accY", int'(dut.u_axisY.r_acc), 0);

    $display("[TB] dx=+5 at 100%%, flip raised after the first count");
    doReset();
    qH.push_back(EV_DIR1); qH.push_back(EV_TOG); qH.push_back(EV_DIR0);
    qH.push_back(EV_TOG); qH.push_back(EV_TOG); qH.push_back(EV_TOG); qH.push_back(EV_TOG);
    applyStimulus(9'sd5, 9'sd0, 1'b0, 1'b0, 2'd2);
    waitQueues(5, 0, 40, "s5_first");
    flip = 1'b1;
    waitQueues(0, 0, 60, "s5_drain");
    checkOutput("s5", 12);
    checkVal("s5_hDir", int'(hDir), 0);
    checkVal("s5_accX", int'(dut.u_axisX.r_acc), 0);

    $display("[TB] 200 packets dx=+255 at 200%%: accumulator saturates");
    doReset();
    freeRunH = 1'b1;
    hDirChanges = 0;
    for (int i = 0; i < 200; i++) applyStimulus(9'sd255, 9'sd0, 1'b0, 1'b0, 2'd3);
    @(posedge clk); #2;
    checkVal("s6_accSat", int'(dut.u_axisX.r_acc), 8191);
    repeat (20) @(posedge clk);
    #2;
    checkVal("s6_hDir", int'(hDir), 1);
    checkVal("s6_dirChanges", hDirChanges, 1);

    $display("[TB] reset mid-stream with a strobe toggle during reset");
    reset = 1'b1;
    ps2Mouse[15:8] = 8'd50;
    ps2Mouse[24]   = ~ps2Mouse[24];
    @(posedge clk); #2;
    freeRunH = 1'b0;
    checkVal("s7_hClk", int'(hClk), 0);
    checkVal("s7_hDir", int'(hDir), 0);
    checkVal("s7_accX", int'(dut.u_axisX.r_acc), 0);
    reset = 1'b0;
    checkOutput("s7_idle", 40);

    $display("[TB] reset while accX=40");
    doReset();
    applyStimulus(9'sd10, 9'sd0, 1'b0, 1'b0, 2'd2);
    @(posedge clk); #2;
    checkVal("s8_accBefore", int'(dut.u_axisX.r_acc), 40);
    reset = 1'b1;
    @(posedge clk); #2;
    checkVal("s8_hClk", int'(hClk), 0);
    checkVal("s8_hDir", int'(hDir), 0);
    checkVal("s8_vClk", int'(vClk), 0);
    checkVal("s8_vDir", int'(vDir), 0);
    checkVal("s8_accX", int'(dut.u_axisX.r_acc), 0);
    reset = 1'b0;
    checkOutput("s8_idle", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
